axi4lite_ram_slave: RTL and testbench

- AXI4-Lite responder (slave) serving the core's data read and write buses from an internal word-addressed RAM.
- Sits opposite the core's data_rbus/data_wbus initiator ports in test tops and the SoC data path.
- Replaces the always-ready combinational ROM stub with true registered handshakes.
- Supports back-pressure, independent address/data arrival on writes, and byte strobes.

---
 rtl/axi4lite_pkg.sv | 13 +
 rtl/axi4lite_ram_slave_ram.sv | 41 ++++
 rtl/axi4lite_ram_slave.sv | 168 ++++++++++++++++
 tb/tb_axi4lite_ram_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite RAM responder: response codes and FSM state encodings.
package axi4lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  typedef enum logic [1:0] {W_IDLE, W_NEED_DATA, W_NEED_ADDR, W_RESP} wr_state_t;

endpackage

// File: rtl/axi4lite_ram_slave_ram.sv
// 32-bit word RAM with one registered read port and one byte-enabled write port.
// Read samples the array before a same-edge write lands (read-before-write).
module ram_1r1w_be #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic             rd_clr_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic [3:0]       wr_be_i
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Output register is reset so r_data reads zero after reset; the array itself is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_clr_i ? 32'h0 : mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi4lite_ram_slave.sv
// AXI4-Lite responder backed by ram_1r1w_be; independent read and write FSMs.
// Define AXI_RAM_ERR_RESP_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module axi4lite_ram_slave
  import axi4lite_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  parameter  int ADDR_W      = 32,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_valid,
  output logic              ar_ready,
  output logic [31:0]       r_data,
  output logic [1:0]        r_resp,
  output logic              r_valid,
  input  logic              r_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [31:0]       w_data,
  input  logic [3:0]        w_strb,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [1:0]        b_resp,
  output logic              b_valid,
  input  logic              b_ready
);

  rd_state_t   rstate_q;
  logic        ar_ready_q, r_valid_q;
  resp_t       r_resp_q;

  wr_state_t   wstate_q;
  logic        aw_ready_q, w_ready_q, b_valid_q;
  resp_t       b_resp_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic              ar_hs, aw_hs, w_hs, wr_fire;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;
  logic [3:0]        wr_strb_d;
  logic              rd_err, wr_err;
  logic              unused_addr_bits;

  assign ar_hs = ar_valid & ar_ready_q;
  assign aw_hs = aw_valid & aw_ready_q;
  assign w_hs  = w_valid & w_ready_q;

  // Whichever channel arrived first comes from its holding register, the other live.
  always_comb begin
    wr_addr_d = (wstate_q == W_NEED_DATA) ? awaddr_q : aw_addr;
    wr_data_d = (wstate_q == W_NEED_ADDR) ? wdata_q  : w_data;
    wr_strb_d = (wstate_q == W_NEED_ADDR) ? wstrb_q  : w_strb;
    wr_fire   = 1'b0;
    case (wstate_q)
      W_IDLE:      wr_fire = aw_hs & w_hs;
      W_NEED_DATA: wr_fire = w_hs;
      W_NEED_ADDR: wr_fire = aw_hs;
      default:     wr_fire = 1'b0;
    endcase
  end

`ifdef AXI_RAM_ERR_RESP_EN
  assign rd_err = |ar_addr[ADDR_W-1:IDX_W+2];
  assign wr_err = |wr_addr_d[ADDR_W-1:IDX_W+2];
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  assign unused_addr_bits = ^{ar_addr[1:0], ar_addr[ADDR_W-1:IDX_W+2],
                              wr_addr_d[1:0], wr_addr_d[ADDR_W-1:IDX_W+2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q   <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: if (ar_hs) begin
          r_valid_q  <= 1'b1;
          ar_ready_q <= 1'b0;
          r_resp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          rstate_q   <= R_RESP;
        end
        R_RESP: if (r_ready) begin
          r_valid_q  <= 1'b0;
          ar_ready_q <= 1'b1;
          rstate_q   <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q   <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      if (wr_fire) begin
        aw_ready_q <= 1'b0;
        w_ready_q  <= 1'b0;
        b_valid_q  <= 1'b1;
        b_resp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
        wstate_q   <= W_RESP;
      end else begin
        case (wstate_q)
          W_IDLE: begin
            if (aw_hs) begin
              aw_ready_q <= 1'b0;
              wstate_q   <= W_NEED_DATA;
            end else if (w_hs) begin
              w_ready_q  <= 1'b0;
              wstate_q   <= W_NEED_ADDR;
            end
          end
          W_RESP: if (b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            wstate_q   <= W_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wstate_q == W_IDLE && aw_hs) awaddr_q <= aw_addr;
    if (wstate_q == W_IDLE && w_hs) begin
      wdata_q <= w_data;
      wstrb_q <= w_strb;
    end
  end

  ram_1r1w_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (ar_hs),
    .rd_clr_i  (rd_err),
    .rd_idx_i  (ar_addr[IDX_W+1:2]),
    .rd_data_o (r_data),
    .we_i      (wr_fire & ~wr_err),
    .wr_idx_i  (wr_addr_d[IDX_W+1:2]),
    .wr_data_i (wr_data_d),
    .wr_be_i   (wr_strb_d)
  );

  assign ar_ready = ar_ready_q;
  assign r_valid  = r_valid_q;
  assign r_resp   = r_resp_q;
  assign aw_ready = aw_ready_q;
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign b_resp   = b_resp_q;

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Scoreboard bench for axi4lite_ram_slave; follows AXI_RAM_ERR_RESP_EN if defined.
module tb_axi4lite_ram_slave;

  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ar_addr = '0, aw_addr = '0, w_data = '0;
  logic        ar_valid = 1'b0, aw_valid = 1'b0, w_valid = 1'b0;
  logic        r_ready = 1'b1, b_ready = 1'b1;
  logic [3:0]  w_strb = '0;
  logic        ar_ready, r_valid, aw_ready, w_ready, b_valid;
  logic [31:0] r_data;
  logic [1:0]  r_resp, b_resp;

  axi4lite_ram_slave #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [DEPTH];
  logic [33:0] rq [$];
  logic [1:0]  bq [$];
  logic [33:0] mon_r;
  logic [1:0]  mon_b;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
`ifdef AXI_RAM_ERR_RESP_EN
    return a[31:IDX_W+2] == '0;
`else
    return a[0] | 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[IDX_W+1:2]);
  endfunction

  function automatic logic [1:0] model_wr(input logic [31:0] a, input logic [31:0] d,
                                          input logic [3:0] s);
    if (!in_rng(a)) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_rd(input logic [31:0] a);
    if (!in_rng(a)) return {2'b10, 32'h0};
    return {2'b00, model[widx(a)]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (r_valid && r_ready) begin
        if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
        else begin
          mon_r = rq.pop_front();
          chk("r_data", r_data, mon_r[31:0]);
          chk("r_resp", {30'd0, r_resp}, {30'd0, mon_r[33:32]});
        end
      end
      if (b_valid && b_ready) begin
        if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
        else begin
          mon_b = bq.pop_front();
          chk("b_resp", {30'd0, b_resp}, {30'd0, mon_b});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk("drain", rq.size() + bq.size(), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bq.push_back(model_wr(a, d, s));
    aw_addr = a; w_data = d; w_strb = s;
    aw_valid = 1'b1; w_valid = 1'b1;
    while (!(aw_ready && w_ready) && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("wr_hs_timeout", 32'd0, 32'd1);
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("b_latency", {31'd0, b_valid}, 32'd1);
    drain();
  endtask

  task automatic rd(input logic [31:0] a);
    int n = 0;
    rq.push_back(model_rd(a));
    ar_addr = a; ar_valid = 1'b1;
    while (!ar_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("rd_hs_timeout", 32'd0, 32'd1);
    step();
    ar_valid = 1'b0;
    chk("r_latency", {31'd0, r_valid}, 32'd1);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    #2 rst = 1'b1;
    #1;
    chk("rst_ar_ready", {31'd0, ar_ready}, 32'd1);
    chk("rst_aw_w_ready", {30'd0, aw_ready, w_ready}, 32'd3);
    chk("rst_valids", {30'd0, r_valid, b_valid}, 32'd0);
    chk("rst_r_data", r_data, 32'd0);
    chk("rst_resps", {28'd0, r_resp, b_resp}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10);

    wr(32'h20, 32'h11223344, 4'hF);
    wr(32'h20, 32'hAABBCCDD, 4'b0101);
    rd(32'h20);
    wr(32'h20, 32'hFFFFFFFF, 4'h0);
    rd(32'h20);

    // address first, data three cycles later; aw_addr scrambled to prove it was latched
    bq.push_back(model_wr(32'h30, 32'h5A5A5A5A, 4'hF));
    aw_addr = 32'h30; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0; aw_addr = 32'h0000_0FF0;
    for (int i = 0; i < 2; i++) begin
      chk("split_aw_ready_low", {31'd0, aw_ready}, 32'd0);
      step();
    end
    w_data = 32'h5A5A5A5A; w_strb = 4'hF; w_valid = 1'b1;
    chk("split_aw_ready_low", {31'd0, aw_ready}, 32'd0);
    step();
    w_valid = 1'b0;
    chk("split_b_valid", {31'd0, b_valid}, 32'd1);
    step();
    chk("split_aw_ready_back", {31'd0, aw_ready}, 32'd1);
    drain();
    rd(32'h30);

    bq.push_back(model_wr(32'h34, 32'hA5A5A5A5, 4'hF));
    w_data = 32'hA5A5A5A5; w_strb = 4'hF; w_valid = 1'b1;
    step();
    w_valid = 1'b0; w_data = 32'h0; w_strb = 4'h0;
    for (int i = 0; i < 2; i++) begin
      chk("split_w_ready_low", {31'd0, w_ready}, 32'd0);
      step();
    end
    aw_addr = 32'h34; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    chk("split2_b_valid", {31'd0, b_valid}, 32'd1);
    drain();
    rd(32'h34);

    rq.push_back(model_rd(32'h10));
    r_ready = 1'b0; ar_addr = 32'h10; ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_r_valid", {31'd0, r_valid}, 32'd1);
      chk("bp_r_data", r_data, 32'hDEADBEEF);
      chk("bp_ar_ready", {31'd0, ar_ready}, 32'd0);
      step();
    end
    r_ready = 1'b1;
    step();
    chk("bp_ar_ready_back", {31'd0, ar_ready}, 32'd1);
    chk("bp_r_valid_drop", {31'd0, r_valid}, 32'd0);
    drain();

    // read and write to the same word on the same edge: read must see the old word
    wr(32'h50, 32'hCAFEF00D, 4'hF);
    rq.push_back(model_rd(32'h50));
    bq.push_back(model_wr(32'h50, 32'h01020304, 4'hF));
    ar_addr = 32'h50; aw_addr = 32'h50; w_data = 32'h01020304; w_strb = 4'hF;
    ar_valid = 1'b1; aw_valid = 1'b1; w_valid = 1'b1;
    step();
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    chk("coll_both_valid", {30'd0, r_valid, b_valid}, 32'd3);
    drain();
    rd(32'h50);

    for (int i = 0; i < 6; i++) begin
      a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
      wr(a, $urandom, 4'($urandom_range(0, 15)));
      rd(a);
    end

    wr(32'h0, 32'h12345678, 4'hF);
    wr(32'h1000, 32'h87654321, 4'hF);
    rd(32'h0);
    rd(32'h1000);

    // reset while a write waits for data and a read response is back-pressured
    r_ready = 1'b0;
    ar_addr = 32'h10; ar_valid = 1'b1;
    aw_addr = 32'h10; aw_valid = 1'b1;
    step();
    ar_valid = 1'b0; aw_valid = 1'b0;
    chk("pre_rst_r_valid", {31'd0, r_valid}, 32'd1);
    chk("pre_rst_aw_ready", {31'd0, aw_ready}, 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("arst_readys", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);
    chk("arst_valids", {30'd0, r_valid, b_valid}, 32'd0);
    step();
    rst = 1'b0;
    r_ready = 1'b1;
    rq.delete();
    bq.delete();
    step();
    rd(32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
